awg_sweep_ctrl: RTL

Sequencer that configures and drives the square/DDS waveform generator's tuning inputs: frequency word, amplitude divisor, phase offset and output enable. It supports a fixed tone and a linear frequency sweep, up or down, single-shot or looping. After the first setting, every frequency change is applied only on a phase-accumulator wrap pulse, so the output is phase-continuous. It sits between the UI/key-decode logic (configuration side) and the generator (tuning side).

---
 rtl/awg_pkg.sv | 40 ++++
 rtl/awg_step_calc.sv | 34 +++
 rtl/awg_sweep_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/awg_pkg.sv
// Shared widths, state/mode encodings and mode decode for the AWG sweep sequencer.
package awg_pkg;

    localparam int unsigned FW      = 14;
    localparam int unsigned AW      = 8;
    localparam int unsigned PW      = 8;
    localparam int unsigned DW      = 16;
    localparam int unsigned AMP_MIN = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAITWRAP = 2'd2,
        FIN      = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_TONE = 2'd0,
        MODE_UP   = 2'd1,
        MODE_DOWN = 2'd2
    } mode_t;

    // Zero step or equal endpoints degenerate to a fixed tone.
    function automatic mode_t decode_mode(
        input logic [FW-1:0] f_start,
        input logic [FW-1:0] f_stop,
        input logic [FW-1:0] f_step
    );
        mode_t m;
        if (f_step == '0 || f_start == f_stop) begin
            m = MODE_TONE;
        end else if (f_start > f_stop) begin
            m = MODE_DOWN;
        end else begin
            m = MODE_UP;
        end
        return m;
    endfunction

endpackage

// File: rtl/awg_step_calc.sv
// Next sweep frequency: step toward f_stop with clamp, or wrap to f_start once at f_stop.
module awg_step_calc
    import awg_pkg::*;
(
    input  logic [FW-1:0] cur,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic          down,
    output logic [FW-1:0] next_freq_c
);

    logic [FW:0] sum;
    logic [FW:0] diff;

    // Extra MSB catches overflow (up) and borrow (down) so both clamp to f_stop.
    always_comb begin
        sum         = (FW+1)'(cur) + (FW+1)'(f_step);
        diff        = (FW+1)'(cur) - (FW+1)'(f_step);
        next_freq_c = f_stop;
        if (cur == f_stop) begin
            next_freq_c = f_start;
        end else if (down) begin
            if (!diff[FW] && (diff[FW-1:0] > f_stop)) begin
                next_freq_c = diff[FW-1:0];
            end
        end else begin
            if (sum < (FW+1)'(f_stop)) begin
                next_freq_c = sum[FW-1:0];
            end
        end
    end

endmodule

// File: rtl/awg_sweep_ctrl.sv
// Tone/sweep sequencer driving the generator tuning inputs; frequency changes after
// the first are applied only on accumulator wrap so the output stays phase-continuous.
module awg_sweep_ctrl
    import awg_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [FW-1:0] cfg_f_start,
    input  logic [FW-1:0] cfg_f_stop,
    input  logic [FW-1:0] cfg_f_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [AW-1:0] cfg_amp,
    input  logic [PW-1:0] cfg_phase,
    input  logic          cfg_loop,
    input  logic          start,
    input  logic          abort,
    input  logic          wrap_i,
    output logic          gen_en,
    output logic [FW-1:0] state_freq,
    output logic [AW-1:0] state_amp,
    output logic [PW-1:0] state_phase,
    output logic          busy,
    output logic          done
);

    state_t        state;
    mode_t         mode_q;
    logic [FW-1:0] f_start_q;
    logic [FW-1:0] f_stop_q;
    logic [FW-1:0] f_step_q;
    logic [DW-1:0] dwell_q;
    logic [AW-1:0] amp_q;
    logic [PW-1:0] phase_q;
    logic          loop_q;
    logic [DW-1:0] dwell_cnt;

    logic          cap;
    logic [FW-1:0] eff_f_start;
    logic [DW-1:0] eff_dwell;
    logic [AW-1:0] eff_amp;
    logic [PW-1:0] eff_phase;
    logic [DW-1:0] cfg_dwell_norm;
    logic [AW-1:0] cfg_amp_norm;
    logic [FW-1:0] next_freq_c;

    assign cfg_ready = (state == IDLE);

    // Config being captured this cycle takes effect for a coincident start.
    always_comb begin
        cap            = cfg_valid && cfg_ready;
        cfg_dwell_norm = (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
        cfg_amp_norm   = (cfg_amp == '0) ? AW'(AMP_MIN) : cfg_amp;
        eff_f_start    = cap ? cfg_f_start    : f_start_q;
        eff_dwell      = cap ? cfg_dwell_norm : dwell_q;
        eff_amp        = cap ? cfg_amp_norm   : amp_q;
        eff_phase      = cap ? cfg_phase      : phase_q;
    end

    awg_step_calc u_step_calc (
        .cur         (state_freq),
        .f_start     (f_start_q),
        .f_stop      (f_stop_q),
        .f_step      (f_step_q),
        .down        (mode_q == MODE_DOWN),
        .next_freq_c (next_freq_c)
    );

    // Config capture, sequencer FSM and registered generator outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= MODE_TONE;
            f_start_q   <= '0;
            f_stop_q    <= '0;
            f_step_q    <= '0;
            dwell_q     <= '0;
            amp_q       <= AW'(AMP_MIN);
            phase_q     <= '0;
            loop_q      <= 1'b0;
            dwell_cnt   <= '0;
            gen_en      <= 1'b0;
            state_freq  <= '0;
            state_amp   <= AW'(AMP_MIN);
            state_phase <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cap) begin
                        f_start_q <= cfg_f_start;
                        f_stop_q  <= cfg_f_stop;
                        f_step_q  <= cfg_f_step;
                        dwell_q   <= cfg_dwell_norm;
                        amp_q     <= cfg_amp_norm;
                        phase_q   <= cfg_phase;
                        loop_q    <= cfg_loop;
                        mode_q    <= decode_mode(cfg_f_start, cfg_f_stop, cfg_f_step);
                    end
                    if (start && !abort) begin
                        state       <= RUN;
                        gen_en      <= 1'b1;
                        busy        <= 1'b1;
                        state_freq  <= eff_f_start;
                        state_amp   <= eff_amp;
                        state_phase <= eff_phase;
                        dwell_cnt   <= eff_dwell - DW'(1);
                    end
                end
                RUN: begin
                    if (abort) begin
                        state  <= IDLE;
                        gen_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (mode_q != MODE_TONE) begin
                        if (dwell_cnt == '0) begin
                            if (state_freq == f_stop_q && !loop_q) begin
                                state  <= FIN;
                                gen_en <= 1'b0;
                                done   <= 1'b1;
                            end else begin
                                state <= WAITWRAP;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt - DW'(1);
                        end
                    end
                end
                WAITWRAP: begin
                    if (abort) begin
                        state  <= IDLE;
                        gen_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (wrap_i) begin
                        state_freq <= next_freq_c;
                        dwell_cnt  <= dwell_q - DW'(1);
                        state      <= RUN;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    gen_en <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    gen_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
